// File: rtl/jk_bank_arbiter_if.sv
// jk_bank_arbiter_if: request/grant and bank-drive bundle for jk_bank_arbiter.
// Requesters sit on the master side; the arbiter sits on the slave side.
interface jk_bank_arbiter_if #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   parameter int AW    = 3
);
   logic [NREQ-1:0]    req;
   logic [2*NREQ-1:0]  op;
   logic [AW*NREQ-1:0] addr;
   logic [NREQ-1:0]    gnt;
   logic [WIDTH-1:0]   J_o;
   logic [WIDTH-1:0]   K_o;
   logic [WIDTH-1:0]   Q;
   logic               busy;
   logic               done;
   logic               err;

   modport master (
      output req, op, addr,
      input  gnt, J_o, K_o, Q, busy, done, err
   );

   modport slave (
      input  req, op, addr,
      output gnt, J_o, K_o, Q, busy, done, err
   );
endinterface

// File: rtl/jk_bank_arbiter.sv
// jk_bank_arbiter: arbitrates single-bit JK operations from NREQ requesters onto
// one bank of WIDTH JK cells, sequencing IDLE -> GRANT -> APPLY -> SETTLE.
// Optional feature macro JK_ARB_RR_EN: when defined, round-robin arbitration
// with a rotating pointer; when undefined, fixed priority (requester 0 highest).
module jk_bank_arbiter #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   parameter int AW    = 3
) (
   input  logic         CLK,
   input  logic         RST,
   jk_bank_arbiter_if.slave bus
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT  = 2'd1,
      APPLY  = 2'd2,
      SETTLE = 2'd3
   } state_t;

   state_t           state, state_nxt;
   logic [PW-1:0]    win_q, win_nxt;
   logic [1:0]       op_q, op_sel;
   logic [AW-1:0]    addr_q, addr_sel;
   logic [WIDTH-1:0] q_r;
   logic             any_req;
   logic             in_range;

   assign any_req  = |bus.req;
   // An address equal to or above WIDTH names no cell and is flagged at SETTLE.
   assign in_range = ({1'b0, addr_q} < (AW+1)'(WIDTH));

`ifdef JK_ARB_RR_EN
   logic [PW-1:0] ptr_q;
   logic [PW-1:0] idx;
   logic          found;

   // Round-robin search: first requester at or after the pointer, wrapping.
   always_comb begin
      win_nxt = '0;
      idx     = '0;
      found   = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         idx = PW'((int'(ptr_q) + i) % NREQ);
         if (!found && bus.req[idx]) begin
            found   = 1'b1;
            win_nxt = idx;
         end
      end
   end

   // Pointer moves past the winner when its grant is issued.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         ptr_q <= '0;
      else if (state == GRANT)
         ptr_q <= (win_q == PW'(NREQ-1)) ? '0 : win_q + 1'b1;
   end
`else
   // Fixed priority: lowest-numbered active requester wins.
   always_comb begin
      win_nxt = '0;
      for (int i = NREQ-1; i >= 0; i--) begin
         if (bus.req[i])
            win_nxt = PW'(i);
      end
   end
`endif

   // State register; reset aborts any in-flight operation.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next-state sequencing; every op passes through all four states.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (any_req) state_nxt = GRANT;
         GRANT:   state_nxt = APPLY;
         APPLY:   state_nxt = SETTLE;
         SETTLE:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Select the winner's op/addr fields out of the packed request buses.
   always_comb begin
      op_sel   = '0;
      addr_sel = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (win_q == PW'(i)) begin
            op_sel   = bus.op[2*i +: 2];
            addr_sel = bus.addr[AW*i +: AW];
         end
      end
   end

   // Winner is captured in IDLE, its operation during the GRANT cycle.
   always_ff @(posedge CLK) begin
      if (state == IDLE && any_req)
         win_q <= win_nxt;
      if (state == GRANT) begin
         op_q   <= op_sel;
         addr_q <= addr_sel;
      end
   end

   // Bank cells: only the addressed bit changes, at the end of APPLY.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         q_r <= '0;
      end else if (state == APPLY) begin
         for (int i = 0; i < WIDTH; i++) begin
            if (addr_q == AW'(i)) begin
               case (op_q)
                  2'b01:   q_r[i] <= 1'b0;
                  2'b10:   q_r[i] <= 1'b1;
                  2'b11:   q_r[i] <= ~q_r[i];
                  default: q_r[i] <= q_r[i];
               endcase
            end
         end
      end
   end

   // Decoded outputs: gnt in GRANT, J/K drive in APPLY, done/err in SETTLE.
   always_comb begin
      bus.gnt  = '0;
      bus.J_o  = '0;
      bus.K_o  = '0;
      bus.done = 1'b0;
      bus.err  = 1'b0;
      bus.busy = (state != IDLE);
      case (state)
         GRANT: begin
            for (int i = 0; i < NREQ; i++)
               if (win_q == PW'(i)) bus.gnt[i] = 1'b1;
         end
         APPLY: begin
            for (int i = 0; i < WIDTH; i++) begin
               if (in_range && addr_q == AW'(i)) begin
                  bus.J_o[i] = op_q[1];
                  bus.K_o[i] = op_q[0];
               end
            end
         end
         SETTLE: begin
            bus.done = 1'b1;
            bus.err  = ~in_range;
         end
         default: ;
      endcase
   end

   assign bus.Q = q_r;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// tb_jk_bank_arbiter: directed bench for jk_bank_arbiter. One instance with
// WIDTH=8 covers the main function; a second with WIDTH=6 covers out-of-range
// addresses. Expected gnt ordering under contention follows JK_ARB_RR_EN.
module tb_jk_bank_arbiter;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   logic [3:0] g;
   logic [7:0] j, k, q;
   logic       d, e;
   logic [3:0] b;

   jk_bank_arbiter_if #(.NREQ(4), .WIDTH(8), .AW(3)) bus8 ();
   jk_bank_arbiter_if #(.NREQ(4), .WIDTH(6), .AW(3)) bus6 ();

   jk_bank_arbiter #(.NREQ(4), .WIDTH(8), .AW(3)) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus8.slave)
   );

   jk_bank_arbiter #(.NREQ(4), .WIDTH(6), .AW(3)) dut6 (
      .CLK (clk),
      .RST (rst),
      .bus (bus6.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset;
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   // Drives one request from IDLE through to the following IDLE and records
   // gnt (GRANT), J/K (APPLY), Q/done/err (SETTLE) and busy in all four cycles.
   task automatic run_op(input int r, input logic [1:0] o, input logic [2:0] a,
                         output logic [3:0] go, output logic [7:0] jo,
                         output logic [7:0] ko, output logic [7:0] qo,
                         output logic do_, output logic eo, output logic [3:0] bo);
      bus8.req        = '0;
      bus8.req[r]     = 1'b1;
      bus8.op[2*r +: 2]  = o;
      bus8.addr[3*r +: 3] = a;
      tick();
      go    = bus8.gnt;
      bo[3] = bus8.busy;
      bus8.req = '0;
      tick();
      jo    = bus8.J_o;
      ko    = bus8.K_o;
      bo[2] = bus8.busy;
      tick();
      qo    = bus8.Q;
      do_   = bus8.done;
      eo    = bus8.err;
      bo[1] = bus8.busy;
      bus8.op   = '0;
      bus8.addr = '0;
      tick();
      bo[0] = bus8.busy;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      bus8.req = '0; bus8.op = '0; bus8.addr = '0;
      bus6.req = '0; bus6.op = '0; bus6.addr = '0;
      tick();
      tick();
      checks++; if (bus8.Q !== 8'h00) begin errors++; $display("FAIL reset_q got %h want 00", bus8.Q); end
      checks++; if (bus8.gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got %b want 0000", bus8.gnt); end
      checks++; if ({bus8.busy, bus8.done, bus8.err} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {bus8.busy, bus8.done, bus8.err}); end
      checks++; if ({bus8.J_o, bus8.K_o} !== 16'h0000) begin errors++; $display("FAIL reset_jk got %h want 0000", {bus8.J_o, bus8.K_o}); end
      rst = 1'b0;
   endtask

   task automatic test_single_op;
      run_op(0, 2'b10, 3'd3, g, j, k, q, d, e, b);
      checks++; if (g !== 4'b0001) begin errors++; $display("FAIL single_gnt got %b want 0001", g); end
      checks++; if (j !== 8'h08 || k !== 8'h00) begin errors++; $display("FAIL single_jk got %h/%h want 08/00", j, k); end
      checks++; if (q !== 8'h08) begin errors++; $display("FAIL single_q got %h want 08", q); end
      checks++; if (d !== 1'b1 || e !== 1'b0) begin errors++; $display("FAIL single_done got %b%b want 10", d, e); end
      checks++; if (b !== 4'b1110) begin errors++; $display("FAIL single_busy got %b want 1110", b); end
      checks++; if (bus8.done !== 1'b0) begin errors++; $display("FAIL single_done_pulse got %b want 0", bus8.done); end
   endtask

   task automatic test_toggle;
      pulse_reset();
      run_op(2, 2'b11, 3'd5, g, j, k, q, d, e, b);
      checks++; if (g !== 4'b0100) begin errors++; $display("FAIL toggle1_gnt got %b want 0100", g); end
      checks++; if (j !== 8'h20 || k !== 8'h20) begin errors++; $display("FAIL toggle1_jk got %h/%h want 20/20", j, k); end
      checks++; if (q !== 8'h20) begin errors++; $display("FAIL toggle1_q got %h want 20", q); end
      run_op(2, 2'b11, 3'd5, g, j, k, q, d, e, b);
      checks++; if (q !== 8'h00) begin errors++; $display("FAIL toggle2_q got %h want 00", q); end
      run_op(1, 2'b10, 3'd5, g, j, k, q, d, e, b);
      checks++; if (q !== 8'h20) begin errors++; $display("FAIL set5_q got %h want 20", q); end
      run_op(1, 2'b00, 3'd5, g, j, k, q, d, e, b);
      checks++; if (q !== 8'h20 || d !== 1'b1) begin errors++; $display("FAIL hold_q got %h/%b want 20/1", q, d); end
      checks++; if (j !== 8'h00 || k !== 8'h00) begin errors++; $display("FAIL hold_jk got %h/%h want 00/00", j, k); end
      run_op(1, 2'b01, 3'd5, g, j, k, q, d, e, b);
      checks++; if (j !== 8'h00 || k !== 8'h20) begin errors++; $display("FAIL reset_op_jk got %h/%h want 00/20", j, k); end
      checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_op_q got %h want 00", q); end
   endtask

   task automatic test_contention;
      logic [3:0] exp_seq [5];
      logic [3:0] exp_g;
      logic [7:0] exp_q;
`ifdef JK_ARB_RR_EN
      exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0100;
      exp_seq[3] = 4'b1000; exp_seq[4] = 4'b0001;
      exp_q = 8'h0F;
`else
      for (int i = 0; i < 5; i++) exp_seq[i] = 4'b0001;
      exp_q = 8'h03;
`endif
      pulse_reset();
      bus8.op   = 8'b10_10_10_10;
      bus8.addr = {3'd3, 3'd2, 3'd1, 3'd0};
      bus8.req  = 4'b1111;
      for (int c = 1; c <= 20; c++) begin
         tick();
         exp_g = ((c - 1) % 4 == 0) ? exp_seq[(c - 1) / 4] : 4'b0000;
         checks++; if (bus8.gnt !== exp_g) begin errors++; $display("FAIL contend_gnt cycle %0d got %b want %b", c, bus8.gnt, exp_g); end
      end
      bus8.req = 4'b1110;
      tick();
      checks++; if (bus8.gnt !== 4'b0010) begin errors++; $display("FAIL contend_drop0_gnt got %b want 0010", bus8.gnt); end
      bus8.req = '0;
      tick();
      tick();
      checks++; if (bus8.Q !== exp_q || bus8.done !== 1'b1) begin errors++; $display("FAIL contend_q got %h/%b want %h/1", bus8.Q, bus8.done, exp_q); end
      bus8.op = '0; bus8.addr = '0;
      tick();
   endtask

   task automatic test_out_of_range;
      bus6.req       = 4'b0001;
      bus6.op[1:0]   = 2'b10;
      bus6.addr[2:0] = 3'd7;
      tick();
      checks++; if (bus6.gnt !== 4'b0001) begin errors++; $display("FAIL oor_gnt got %b want 0001", bus6.gnt); end
      bus6.req = '0;
      tick();
      checks++; if (bus6.J_o !== 6'h00 || bus6.K_o !== 6'h00) begin errors++; $display("FAIL oor_jk got %h/%h want 00/00", bus6.J_o, bus6.K_o); end
      tick();
      checks++; if (bus6.done !== 1'b1 || bus6.err !== 1'b1) begin errors++; $display("FAIL oor_done_err got %b%b want 11", bus6.done, bus6.err); end
      checks++; if (bus6.Q !== 6'h00) begin errors++; $display("FAIL oor_q got %h want 00", bus6.Q); end
      bus6.op = '0; bus6.addr = '0;
      tick();
      checks++; if (bus6.err !== 1'b0 || bus6.busy !== 1'b0) begin errors++; $display("FAIL oor_after got %b%b want 00", bus6.err, bus6.busy); end
   endtask

   task automatic test_reset_in_apply;
      for (int i = 0; i < 8; i++)
         run_op(0, 2'b10, 3'(i), g, j, k, q, d, e, b);
      checks++; if (bus8.Q !== 8'hFF) begin errors++; $display("FAIL fill_q got %h want FF", bus8.Q); end
      bus8.req = 4'b1000;
      bus8.op[7:6] = 2'b11;
      bus8.addr[11:9] = 3'd0;
      tick();
      bus8.req = '0;
      tick();
      checks++; if (bus8.J_o !== 8'h01 || bus8.busy !== 1'b1) begin errors++; $display("FAIL apply_before_rst got %h/%b want 01/1", bus8.J_o, bus8.busy); end
      #2 rst = 1'b1;
      #1;
      checks++; if (bus8.Q !== 8'h00 || bus8.busy !== 1'b0) begin errors++; $display("FAIL rst_apply_q got %h/%b want 00/0", bus8.Q, bus8.busy); end
      tick();
      checks++; if (bus8.done !== 1'b0) begin errors++; $display("FAIL rst_apply_done1 got %b want 0", bus8.done); end
      tick();
      checks++; if (bus8.done !== 1'b0) begin errors++; $display("FAIL rst_apply_done2 got %b want 0", bus8.done); end
      rst = 1'b0;
      bus8.op = '0; bus8.addr = '0;
      run_op(0, 2'b10, 3'd1, g, j, k, q, d, e, b);
      checks++; if (g !== 4'b0001) begin errors++; $display("FAIL post_rst_gnt got %b want 0001", g); end
      checks++; if (q !== 8'h02 || d !== 1'b1) begin errors++; $display("FAIL post_rst_q got %h/%b want 02/1", q, d); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_single_op();
      test_toggle();
      test_contention();
      test_out_of_range();
      test_reset_in_apply();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
